rv32_mem_mmio_bus: RTL and testbench

- Memory-side stage directly downstream of the multicycle core's single memory port (mem_addr, mem_wr_data, mem_wr_ena in; mem_rd_data out).
- Decodes each word address to on-chip RAM, a small MMIO register bank (LEDs, switches, 64-bit cycle counter, compare timer) or unmapped space.
- Owns the RAM instance and returns registered read data with 1-cycle latency, matching the core's fetch/memread state timing.

---
 rtl/rv32_mmio_pkg.sv | 18 +
 rtl/sync_ram_word.sv | 26 ++
 rtl/rv32_mem_mmio_bus.sv | 118 +++++++++++
 tb/tb_rv32_mem_mmio_bus.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rv32_mmio_pkg.sv
// rtl/rv32_mmio_pkg.sv - shared MMIO offsets and address region type for the memory-side bus
package rv32_mmio_pkg;

   localparam logic [7:0] MMIO_LED    = 8'h00;
   localparam logic [7:0] MMIO_SW     = 8'h04;
   localparam logic [7:0] MMIO_CYC_LO = 8'h08;
   localparam logic [7:0] MMIO_CYC_HI = 8'h0C;
   localparam logic [7:0] MMIO_CMP    = 8'h10;
   localparam logic [7:0] MMIO_CTRL   = 8'h14;
   localparam logic [7:0] MMIO_STATUS = 8'h18;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_NONE
   } region_t;

endpackage

// File: rtl/sync_ram_word.sv
// rtl/sync_ram_word.sv - single-port 32-bit word RAM, synchronous read-first
module sync_ram_word #(
   parameter int DEPTH     = 1024,
   parameter     INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic [31:0]              wdata_i,
   output logic [31:0]              rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Read samples the pre-write contents, so a same-address write returns old data.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32_mem_mmio_bus.sv
// rtl/rv32_mem_mmio_bus.sv - address decode, RAM, MMIO registers and cycle/compare timer
module rv32_mem_mmio_bus
   import rv32_mmio_pkg::*;
#(
   parameter int          RAM_WORDS = 1024,
   parameter              INIT_FILE = "",
   parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
   parameter int          LED_W     = 16,
   parameter int          SW_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wr_data,
   input  logic             mem_wr_ena,
   output logic [31:0]      mem_rd_data,
   input  logic [SW_W-1:0]  switches,
   output logic [LED_W-1:0] leds,
   output logic             irq_timer,
   output logic             bus_err
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

   region_t     region, region_q;
   logic [7:0]  off;
   logic        ram_we, mmio_we, off_rd_ok, off_wr_ok, bus_err_set;
   logic        cyc_clr, match_set, w1c;
   logic [31:0] mmio_rdata, mmio_rd_q, ram_rdata;
   logic [63:0] cnt_q, cnt_d;
   logic [31:0] hi_q, cmp_q;
   logic [LED_W-1:0] led_q;
   logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
   logic        irq_en_q, match_q, bus_err_q;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^mem_addr[1:0];
   assign off = {mem_addr[7:2], 2'b00};

   always_comb begin
      region = REGION_NONE;
      if ({1'b0, mem_addr} < RAM_BYTES)              region = REGION_RAM;
      else if (mem_addr[31:8] == MMIO_BASE[31:8])    region = REGION_MMIO;
   end

   always_comb begin
      off_rd_ok  = 1'b1;
      off_wr_ok  = 1'b1;
      mmio_rdata = '0;
      case (off)
         MMIO_LED:    mmio_rdata = 32'(led_q);
         MMIO_SW:     begin mmio_rdata = 32'(sw_s2_q); off_wr_ok = 1'b0; end
         MMIO_CYC_LO: mmio_rdata = cnt_q[31:0];
         MMIO_CYC_HI: begin mmio_rdata = hi_q; off_wr_ok = 1'b0; end
         MMIO_CMP:    mmio_rdata = cmp_q;
         MMIO_CTRL:   mmio_rdata = {31'b0, irq_en_q};
         MMIO_STATUS: mmio_rdata = {31'b0, match_q};
         default:     begin off_rd_ok = 1'b0; off_wr_ok = 1'b0; end
      endcase
   end

   assign ram_we      = mem_wr_ena && (region == REGION_RAM);
   assign mmio_we     = mem_wr_ena && (region == REGION_MMIO) && off_wr_ok;
   assign bus_err_set = mem_wr_ena && ((region == REGION_NONE) ||
                        ((region == REGION_MMIO) && !off_wr_ok));
   assign cyc_clr     = mmio_we && (off == MMIO_CYC_LO);
   assign w1c         = mmio_we && (off == MMIO_STATUS) && mem_wr_data[0];
   assign match_set   = (cnt_q[31:0] == cmp_q);
   assign cnt_d       = cyc_clr ? 64'd0 : cnt_q + 64'd1;

   // RAM writes are not gated by rst, so a write alongside reset still lands.
   sync_ram_word #(
      .DEPTH     (RAM_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (mem_addr[AW+1:2]),
      .wdata_i (mem_wr_data),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         region_q  <= REGION_NONE;
         mmio_rd_q <= '0;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         cmp_q     <= 32'hFFFF_FFFF;
         led_q     <= '0;
         irq_en_q  <= 1'b0;
         match_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         region_q  <= region;
         mmio_rd_q <= ((region == REGION_MMIO) && off_rd_ok) ? mmio_rdata : 32'd0;
         sw_s1_q   <= switches;
         sw_s2_q   <= sw_s1_q;
         cnt_q     <= cnt_d;
         // Latching the high word on a LO read keeps the LO/HI pair coherent.
         if ((region == REGION_MMIO) && (off == MMIO_CYC_LO)) hi_q <= cnt_q[63:32];
         if (mmio_we && (off == MMIO_LED))  led_q    <= mem_wr_data[LED_W-1:0];
         if (mmio_we && (off == MMIO_CMP))  cmp_q    <= mem_wr_data;
         if (mmio_we && (off == MMIO_CTRL)) irq_en_q <= mem_wr_data[0];
         match_q <= match_set || (match_q && !w1c);
         if (bus_err_set) bus_err_q <= 1'b1;
      end
   end

   assign mem_rd_data = (region_q == REGION_RAM) ? ram_rdata : mmio_rd_q;
   assign leds        = led_q;
   assign irq_timer   = match_q && irq_en_q;
   assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_rv32_mem_mmio_bus.sv
// tb/tb_rv32_mem_mmio_bus.sv - directed table-driven bench for rv32_mem_mmio_bus
module tb_rv32_mem_mmio_bus;

   localparam logic [31:0] A_LED    = 32'hF000_0000;
   localparam logic [31:0] A_SW     = 32'hF000_0004;
   localparam logic [31:0] A_CYC_LO = 32'hF000_0008;
   localparam logic [31:0] A_CYC_HI = 32'hF000_000C;
   localparam logic [31:0] A_CMP    = 32'hF000_0010;
   localparam logic [31:0] A_CTRL   = 32'hF000_0014;
   localparam logic [31:0] A_STATUS = 32'hF000_0018;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wr_data = '0;
   logic        mem_wr_ena = 1'b0;
   logic [31:0] mem_rd_data;
   logic [15:0] switches = 16'h3C5A;
   logic [15:0] leds;
   logic        irq_timer;
   logic        bus_err;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        rst;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [15:0] exp_leds;
      logic        exp_err;
   } vec_t;

   vec_t vec_a[$];
   vec_t vec_b[$];

   rv32_mem_mmio_bus dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ena  (mem_wr_ena),
      .mem_rd_data (mem_rd_data),
      .switches    (switches),
      .leds        (leds),
      .irq_timer   (irq_timer),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [31:0] a, input logic [31:0] d,
                               input logic w, input logic c, input logic [31:0] er,
                               input logic [15:0] el, input logic ee);
      vec_t v;
      v.rst = r; v.addr = a; v.wdata = d; v.we = w;
      v.chk_rd = c; v.exp_rd = er; v.exp_leds = el; v.exp_err = ee;
      return v;
   endfunction

   task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w);
      rst = r; mem_addr = a; mem_wr_data = d; mem_wr_ena = w;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic run_vec(input string tag, input vec_t v, input int idx);
      step(v.rst, v.addr, v.wdata, v.we);
      if (v.chk_rd) chk($sformatf("%s[%0d].rd", tag, idx), mem_rd_data, v.exp_rd);
      chk($sformatf("%s[%0d].leds", tag, idx), 32'(leds), 32'(v.exp_leds));
      chk($sformatf("%s[%0d].bus_err", tag, idx), 32'(bus_err), 32'(v.exp_err));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //               rst  addr          wdata          we  chk  exp_rd         leds      err
      vec_a.push_back(mk(0, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0,         16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0010, 32'h0,         0, 1, 32'hDEAD_BEEF, 16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0010, 32'h1234_5678, 1, 1, 32'hDEAD_BEEF, 16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678, 16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0014, 32'h0BAD_F00D, 1, 0, 32'h0,         16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678, 16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0014, 32'h0,         0, 1, 32'h0BAD_F00D, 16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0FFC, 32'hA1B2_C3D4, 1, 0, 32'h0,         16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_0FFF, 32'h0,         0, 1, 32'hA1B2_C3D4, 16'h0,    0));
      vec_a.push_back(mk(0, 32'h0000_1000, 32'h0,         0, 1, 32'h0,         16'h0,    0));
      vec_a.push_back(mk(0, A_LED,         32'h0001_A5A5, 1, 0, 32'h0,         16'hA5A5, 0));
      vec_a.push_back(mk(0, A_LED,         32'h0,         0, 1, 32'h0000_A5A5, 16'hA5A5, 0));
      vec_a.push_back(mk(0, A_SW,          32'h0,         0, 1, 32'h0000_3C5A, 16'hA5A5, 0));
      vec_a.push_back(mk(0, 32'hF000_001C, 32'h0,         0, 1, 32'h0,         16'hA5A5, 0));

      vec_b.push_back(mk(0, 32'h8000_0000, 32'hCAFE_F00D, 1, 0, 32'h0,         16'hA5A5, 1));
      vec_b.push_back(mk(0, 32'h8000_0000, 32'h0,         0, 1, 32'h0,         16'hA5A5, 1));
      vec_b.push_back(mk(0, 32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678, 16'hA5A5, 1));
      vec_b.push_back(mk(0, A_LED,         32'h0,         0, 1, 32'h0000_A5A5, 16'hA5A5, 1));
      vec_b.push_back(mk(0, A_CMP,         32'h0,         0, 1, 32'd50,        16'hA5A5, 1));
      vec_b.push_back(mk(1, 32'h0000_0020, 32'h55AA_55AA, 1, 1, 32'h0,         16'h0,    0));
      vec_b.push_back(mk(0, 32'h0000_0020, 32'h0,         0, 1, 32'h55AA_55AA, 16'h0,    0));
      vec_b.push_back(mk(0, 32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678, 16'h0,    0));
      vec_b.push_back(mk(0, A_SW,          32'h0000_1234, 1, 0, 32'h0,         16'h0,    1));
      vec_b.push_back(mk(0, A_SW,          32'h0,         0, 1, 32'h0000_3C5A, 16'h0,    1));
      vec_b.push_back(mk(0, A_CMP,         32'h0,         0, 1, 32'hFFFF_FFFF, 16'h0,    1));

      step(1, 32'h0, 32'h0, 0);
      step(1, 32'h0, 32'h0, 0);
      chk("reset.rd", mem_rd_data, 32'h0);
      chk("reset.leds", 32'(leds), 32'h0);
      chk("reset.irq", 32'(irq_timer), 32'h0);
      chk("reset.bus_err", 32'(bus_err), 32'h0);
      step(0, A_CYC_LO, 32'h0, 0);
      n_total++;
      if (mem_rd_data <= 32'd2) n_pass++;
      else $display("FAIL reset.cycle_count: got %0d expected at most 2", mem_rd_data);

      foreach (vec_a[i]) run_vec("vec_a", vec_a[i], i);

      // Clear lands at edge k; counter reads j after edge k+j, so the read at edge k+101 sees 100.
      step(0, A_CYC_LO, 32'h0, 1);
      repeat (100) step(0, 32'h0, 32'h0, 0);
      step(0, A_CYC_LO, 32'h0, 0);
      chk("counter.lo_100", mem_rd_data, 32'd100);
      step(0, A_CYC_HI, 32'h0, 0);
      chk("counter.hi_0", mem_rd_data, 32'h0);

      step(0, A_CMP, 32'd50, 1);
      step(0, A_CTRL, 32'd1, 1);
      step(0, A_STATUS, 32'd1, 1);
      step(0, A_CYC_LO, 32'h0, 1);
      repeat (50) step(0, 32'h0, 32'h0, 0);
      chk("timer.before_match", 32'(irq_timer), 32'h0);
      step(0, 32'h0, 32'h0, 0);
      chk("timer.at_match", 32'(irq_timer), 32'h1);
      step(0, A_STATUS, 32'h0, 0);
      chk("timer.status_rd", mem_rd_data, 32'h1);
      step(0, A_CTRL, 32'h0, 0);
      chk("timer.ctrl_rd", mem_rd_data, 32'h1);
      step(0, A_STATUS, 32'h0, 1);
      chk("timer.w0_no_effect", 32'(irq_timer), 32'h1);
      step(0, A_STATUS, 32'h1, 1);
      chk("timer.w1c", 32'(irq_timer), 32'h0);
      step(0, A_CYC_LO, 32'h0, 1);
      repeat (50) step(0, 32'h0, 32'h0, 0);
      chk("timer.rearm_low", 32'(irq_timer), 32'h0);
      step(0, A_STATUS, 32'h1, 1);
      chk("timer.set_beats_w1c", 32'(irq_timer), 32'h1);

      force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
      #1;
      release dut.cnt_q;
      step(0, A_CYC_LO, 32'h0, 0);
      chk("pair1.lo", mem_rd_data, 32'hFFFF_FFFF);
      step(0, A_CYC_HI, 32'h0, 0);
      chk("pair1.hi", mem_rd_data, 32'h0);
      step(0, A_CYC_LO, 32'h0, 0);
      chk("pair2.lo", mem_rd_data, 32'h1);
      step(0, A_CYC_HI, 32'h0, 0);
      chk("pair2.hi", mem_rd_data, 32'h1);

      foreach (vec_b[i]) run_vec("vec_b", vec_b[i], i);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
